fum_fetch_stage: RTL



---
 rtl/fum_pkg.sv | 34 +++
 rtl/fum_if_skid.sv | 25 ++
 rtl/fum_fetch_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fum_pkg.sv
// Shared constants and types for the FUM 16-bit core front end.
package fum_pkg;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 16;
   localparam int PC_STEP = 2;
   localparam logic [PC_W-1:0]    RESET_PC  = 8'h00;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

   typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} fetch_state_t;

   typedef struct packed {
      logic               valid;
      logic [INSTR_W-1:0] ir;
      logic [PC_W-1:0]    pc;
      logic [PC_W-1:0]    pc_next;
   } if_id_t;

   localparam if_id_t IF_ID_EMPTY = '{valid: 1'b0, ir: NOP_INSTR, pc: '0, pc_next: '0};

   function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
      return pc + PC_W'(PC_STEP);
   endfunction

   // A bubble keeps the pc fields so decode still sees where the hole sits.
   function automatic if_id_t bubble(input if_id_t cur);
      if_id_t b;
      b       = cur;
      b.valid = 1'b0;
      b.ir    = NOP_INSTR;
      return b;
   endfunction

endpackage

// File: rtl/fum_if_skid.sv
// One-entry holding register for an IF/ID bundle; load wins over drain,
// clear wins over both.
module fum_if_skid
   import fum_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  logic   drain,
   input  logic   clear,
   input  if_id_t din,
   output if_id_t dout
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         dout <= IF_ID_EMPTY;
      end else if (load) begin
         dout <= din;
      end else if (drain) begin
         dout.valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fum_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem request/ack handshake
// and produces the IF/ID register for decode.
//
// state   | meaning
// IDLE    | first cycle after reset, launches the first request
// REQ     | request idle (issue next cycle) or outstanding on the bus
// HOLD    | fetched word parked in the skid while decode stalls
// DISCARD | redirected while a request was in flight; drop its data
module fum_fetch_stage
   import fum_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_ack,
   input  logic               stall_i,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               if_id_valid,
   output logic [INSTR_W-1:0] if_id_ir,
   output logic [PC_W-1:0]    if_id_pc,
   output logic [PC_W-1:0]    if_id_pc_next
);

   fetch_state_t    state;
   logic [PC_W-1:0] pc;
   if_id_t          if_id;
   if_id_t          skid_q;
   if_id_t          fetched;
   logic            ack;
   logic            skid_load;
   logic            skid_drain;

   // An ack without a live request is a protocol error and is ignored.
   assign ack     = imem_ack && imem_req;
   assign fetched = '{valid: 1'b1, ir: imem_rdata, pc: pc, pc_next: pc_inc(pc)};

   assign skid_load  = !rst && !redirect_valid && (state == REQ)  && ack && stall_i;
   assign skid_drain = !rst && !redirect_valid && (state == HOLD) && !stall_i;

   fum_if_skid u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .drain (skid_drain),
      .clear (redirect_valid),
      .din   (fetched),
      .dout  (skid_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         if_id     <= IF_ID_EMPTY;
      end else if (redirect_valid) begin
         if_id <= bubble(if_id);
         pc    <= redirect_pc & ~PC_W'(1);
         case (state)
            REQ: begin
               if (imem_req && !ack) begin
                  state <= DISCARD;
               end else begin
                  imem_req <= 1'b0;
               end
            end
            DISCARD: begin
               if (ack) begin
                  state    <= REQ;
                  imem_req <= 1'b0;
               end
            end
            default: begin
               state    <= REQ;
               imem_req <= 1'b0;
            end
         endcase
      end else begin
         case (state)
            IDLE: begin
               state     <= REQ;
               imem_req  <= 1'b1;
               imem_addr <= pc;
            end
            REQ: begin
               if (!imem_req) begin
                  imem_req  <= 1'b1;
                  imem_addr <= pc;
                  if (!stall_i) if_id <= bubble(if_id);
               end else if (ack) begin
                  pc       <= pc_inc(pc);
                  imem_req <= 1'b0;
                  if (!stall_i) begin
                     if_id <= fetched;
                  end else begin
                     state <= HOLD;
                  end
               end else if (!stall_i) begin
                  if_id <= bubble(if_id);
               end
            end
            HOLD: begin
               if (!stall_i) begin
                  if_id <= skid_q;
                  state <= REQ;
               end
            end
            DISCARD: begin
               if (ack) begin
                  state    <= REQ;
                  imem_req <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign if_id_valid   = if_id.valid;
   assign if_id_ir      = if_id.ir;
   assign if_id_pc      = if_id.pc;
   assign if_id_pc_next = if_id.pc_next;

   ack_needs_req: assert property (@(posedge clk) disable iff (rst) imem_ack |-> imem_req);

endmodule
